sarray_feed_ctrl: RTL and testbench

- Sequences one tile-MMA operation into the systolic array.
- Accepts a command with K beats, type, precision and accumulate flag.
- Pulls K paired beats from the A (left) and B (top) operand buffers and drives the left and top skew shift-register chains. Each beat is tagged with its beat index.
- Waits for the skewed wavefront to drain out of the array, then pulses done.

---
 rtl/sarray_feed_ctrl_pkg.sv | 16 +
 rtl/sarray_feed_stage.sv | 52 +++++
 rtl/sarray_feed_ctrl.sv | 131 +++++++++++++
 tb/tb_sarray_feed_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sarray_feed_ctrl_pkg.sv
// Shared types and default geometry for the systolic-array feed controller.
package sarray_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} feed_state_e;

  localparam int DEF_SARRAY_H = 8;
  localparam int DEF_SARRAY_W = 8;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_PREC_W   = 2;
  localparam int DEF_LOAD_W   = 256;
  localparam int DEF_DRAIN_LEN = DEF_SARRAY_H + DEF_SARRAY_W;

  // Cycles for the last skewed beat to leave the far corner of the array.
  function automatic int drain_len(int h, int w);
    return h + w;
  endfunction
endpackage

// File: rtl/sarray_feed_stage.sv
// Output register for the left/top skew-chain buses; valid clears on idle cycles,
// payload fields hold their last fired value.
module sarray_feed_stage #(
  parameter int CNT_W  = 8,
  parameter int PREC_W = 2,
  parameter int LOAD_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fire,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              op_type,
  input  logic [PREC_W-1:0] precision,
  input  logic              acc,
  input  logic [LOAD_W-1:0] a_data,
  input  logic [LOAD_W-1:0] b_data,
  output logic              left_valid,
  output logic [CNT_W-1:0]  left_cnt,
  output logic              left_type,
  output logic [PREC_W-1:0] left_precision,
  output logic              left_acc,
  output logic [LOAD_W-1:0] left_data,
  output logic              top_valid,
  output logic [CNT_W-1:0]  top_cnt,
  output logic [LOAD_W-1:0] top_data
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_valid     <= 1'b0;
      left_cnt       <= '0;
      left_type      <= 1'b0;
      left_precision <= '0;
      left_acc       <= 1'b0;
      left_data      <= '0;
      top_valid      <= 1'b0;
      top_cnt        <= '0;
      top_data       <= '0;
    end else begin
      left_valid <= fire;
      top_valid  <= fire;
      if (fire) begin
        left_cnt       <= cnt;
        left_type      <= op_type;
        left_precision <= precision;
        left_acc       <= acc;
        left_data      <= a_data;
        top_cnt        <= cnt;
        top_data       <= b_data;
      end
    end
  end
endmodule

// File: rtl/sarray_feed_ctrl.sv
// Sequences one tile-MMA: feeds K paired A/B beats into the skew chains, waits for the
// wavefront to drain, pulses done. Optional macro SARRAY_FEED_PERF_EN adds stall_cnt_o.
module sarray_feed_ctrl
  import sarray_pkg::*;
#(
  parameter int SARRAY_H = DEF_SARRAY_H,
  parameter int SARRAY_W = DEF_SARRAY_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PREC_W   = DEF_PREC_W,
  parameter int LOAD_W   = DEF_LOAD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [CNT_W-1:0]  cmd_k_i,
  input  logic              cmd_type_i,
  input  logic [PREC_W-1:0] cmd_precision_i,
  input  logic              cmd_acc_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [LOAD_W-1:0] a_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [LOAD_W-1:0] b_data_i,
  output logic              left_valid_o,
  output logic [CNT_W-1:0]  left_cnt_o,
  output logic              left_type_o,
  output logic [PREC_W-1:0] left_precision_o,
  output logic              left_acc_o,
  output logic [LOAD_W-1:0] left_data_o,
  output logic              top_valid_o,
  output logic [CNT_W-1:0]  top_cnt_o,
  output logic [LOAD_W-1:0] top_data_o,
  output logic              busy_o,
  output logic              done_o
`ifdef SARRAY_FEED_PERF_EN
  , output logic [15:0]     stall_cnt_o
`endif
);
  localparam int DRAIN_CYC = drain_len(SARRAY_H, SARRAY_W);
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

  feed_state_e       state, state_nxt;
  logic [CNT_W-1:0]  k_q, beat_cnt;
  logic              type_q, acc_q;
  logic [PREC_W-1:0] prec_q;
  logic [DRAIN_W-1:0] drain_cnt;
  logic              accept, fire, last_fire;

  assign accept    = cmd_valid_i & cmd_ready_o;
  // A and B are only ever consumed together so the two buffers stay beat-aligned.
  assign fire      = (state == S_FEED) & a_valid_i & b_valid_i;
  assign last_fire = fire & (beat_cnt == k_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid_i) state_nxt = (cmd_k_i == '0) ? S_DONE : S_FEED;
      S_FEED:  if (last_fire) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == DRAIN_W'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (state == S_IDLE);
    a_ready_o   = fire;
    b_ready_o   = fire;
    busy_o      = (state != S_IDLE);
    done_o      = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      type_q    <= 1'b0;
      prec_q    <= '0;
      acc_q     <= 1'b0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        k_q      <= cmd_k_i;
        type_q   <= cmd_type_i;
        prec_q   <= cmd_precision_i;
        acc_q    <= cmd_acc_i;
        beat_cnt <= '0;
      end else if (fire) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (last_fire)              drain_cnt <= DRAIN_W'(DRAIN_CYC);
      else if (state == S_DRAIN)  drain_cnt <= drain_cnt - DRAIN_W'(1);
    end
  end

`ifdef SARRAY_FEED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                               stall_cnt_o <= '0;
    else if (accept)                                          stall_cnt_o <= '0;
    else if (state == S_FEED && !fire && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

  sarray_feed_stage #(.CNT_W(CNT_W), .PREC_W(PREC_W), .LOAD_W(LOAD_W)) u_stage (
    .clk           (clk),
    .rst_n         (rst_n),
    .fire          (fire),
    .cnt           (beat_cnt),
    .op_type       (type_q),
    .precision     (prec_q),
    .acc           (acc_q),
    .a_data        (a_data_i),
    .b_data        (b_data_i),
    .left_valid    (left_valid_o),
    .left_cnt      (left_cnt_o),
    .left_type     (left_type_o),
    .left_precision(left_precision_o),
    .left_acc      (left_acc_o),
    .left_data     (left_data_o),
    .top_valid     (top_valid_o),
    .top_cnt       (top_cnt_o),
    .top_data      (top_data_o)
  );
endmodule

// File: tb/tb_sarray_feed_ctrl.sv
// Self-checking bench: transaction-timing model of the feed controller, directed cases
// plus randomized commands, backpressure and resets.
module tb_sarray_feed_ctrl;
  localparam int H = 8, W = 8, CW = 8, PW = 2, LW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cmd_valid_i = 0, cmd_type_i = 0, cmd_acc_i = 0;
  logic [CW-1:0] cmd_k_i = '0;
  logic [PW-1:0] cmd_precision_i = '0;
  logic a_valid_i = 0, b_valid_i = 0;
  logic [LW-1:0] a_data_i = '0, b_data_i = '0;
  logic cmd_ready_o, a_ready_o, b_ready_o, left_valid_o, left_type_o, left_acc_o;
  logic top_valid_o, busy_o, done_o;
  logic [CW-1:0] left_cnt_o, top_cnt_o;
  logic [PW-1:0] left_precision_o;
  logic [LW-1:0] left_data_o, top_data_o;
`ifdef SARRAY_FEED_PERF_EN
  logic [15:0] stall_cnt_o;
`endif

  sarray_feed_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_k_i(cmd_k_i),
    .cmd_type_i(cmd_type_i), .cmd_precision_i(cmd_precision_i), .cmd_acc_i(cmd_acc_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i),
    .left_valid_o(left_valid_o), .left_cnt_o(left_cnt_o), .left_type_o(left_type_o),
    .left_precision_o(left_precision_o), .left_acc_o(left_acc_o), .left_data_o(left_data_o),
    .top_valid_o(top_valid_o), .top_cnt_o(top_cnt_o), .top_data_o(top_data_o),
    .busy_o(busy_o), .done_o(done_o)
`ifdef SARRAY_FEED_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a command is "in flight" while beats remain or a done cycle is scheduled.
  int m_cyc = 0, m_rem = 0, m_idx = 0, m_done = -1;
  logic m_type = 0, m_acc = 0;
  logic [PW-1:0] m_prec = '0;
  logic e_lv = 0, e_type = 0, e_acc = 0;
  int e_cnt = 0, e_stall = 0;
  logic [PW-1:0] e_prec = '0;
  logic [LW-1:0] e_a = '0, e_b = '0;

  initial forever begin
    bit mi, mf;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_rem = 0; m_idx = 0; m_done = -1; m_type = 0; m_acc = 0; m_prec = '0;
      e_lv = 0; e_type = 0; e_acc = 0; e_cnt = 0; e_prec = '0; e_a = '0; e_b = '0; e_stall = 0;
    end else begin
      mi = (m_rem == 0 && m_done < 0);
      mf = (m_rem > 0) && a_valid_i && b_valid_i;
      e_lv = 0;
      if (m_rem > 0 && !mf && e_stall < 65535) e_stall++;
      if (m_done == m_cyc) m_done = -1;
      else if (mi && cmd_valid_i) begin
        m_type = cmd_type_i; m_prec = cmd_precision_i; m_acc = cmd_acc_i; e_stall = 0;
        if (cmd_k_i == 0) m_done = m_cyc + 1;
        else begin m_rem = int'(cmd_k_i); m_idx = 0; end
      end else if (mf) begin
        e_lv = 1; e_cnt = m_idx; e_type = m_type; e_prec = m_prec; e_acc = m_acc;
        e_a = a_data_i; e_b = b_data_i;
        m_idx++; m_rem--;
        if (m_rem == 0) m_done = m_cyc + 1 + H + W;
      end
      m_cyc++;
    end
  end

  // Per-cycle compare plus a light log used by the directed literal checks.
  int q_cnt[$];
  logic [3:0] q_meta[$];
  int n_rdy = 0, n_done = 0, last_fire = -1, done_c = -1, first_v = -1, last_v = -1;

  initial forever begin
    bit idle_e, fire_e;
    @(negedge clk);
    idle_e = (m_rem == 0 && m_done < 0);
    fire_e = (m_rem > 0) && a_valid_i && b_valid_i;
    chk("cmd_ready", int'(cmd_ready_o), int'(idle_e));
    chk("a_ready", int'(a_ready_o), int'(fire_e));
    chk("b_ready", int'(b_ready_o), int'(fire_e));
    chk("busy", int'(busy_o), int'(!idle_e));
    chk("done", int'(done_o), int'(m_done == m_cyc));
    chk("left_valid", int'(left_valid_o), int'(e_lv));
    chk("top_valid", int'(top_valid_o), int'(e_lv));
    chk("left_cnt", int'(left_cnt_o), e_cnt);
    chk("top_cnt", int'(top_cnt_o), e_cnt);
    chk("left_type", int'(left_type_o), int'(e_type));
    chk("left_prec", int'(left_precision_o), int'(e_prec));
    chk("left_acc", int'(left_acc_o), int'(e_acc));
    chkw("left_data", left_data_o, e_a);
    chkw("top_data", top_data_o, e_b);
`ifdef SARRAY_FEED_PERF_EN
    chk("stall_cnt", int'(stall_cnt_o), e_stall);
`endif
    if (left_valid_o) begin
      q_cnt.push_back(int'(left_cnt_o));
      q_meta.push_back({left_type_o, left_precision_o, left_acc_o});
      if (first_v < 0) first_v = m_cyc;
      last_v = m_cyc;
    end
    if (a_ready_o) begin n_rdy++; last_fire = m_cyc; end
    if (done_o) begin n_done++; done_c = m_cyc; end
  end

  function automatic logic [LW-1:0] rnd_data();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    a_data_i = rnd_data();
    b_data_i = rnd_data();
  endtask

  task automatic clear_log();
    q_cnt.delete(); q_meta.delete();
    n_rdy = 0; n_done = 0; last_fire = -1; done_c = -1; first_v = -1; last_v = -1;
  endtask

  task automatic wait_done(string name, int max);
    for (int i = 0; i < max && n_done == 0; i++) tick();
    chk({name, "_done_seen"}, n_done, 1);
  endtask

  task automatic send(int k, logic t, logic [PW-1:0] p, logic ac);
    cmd_valid_i = 1; cmd_k_i = CW'(k); cmd_type_i = t; cmd_precision_i = p; cmd_acc_i = ac;
  endtask

  int acc_c;

  initial begin
    repeat (3) tick();
    chk("rst_ready", int'(cmd_ready_o), 1);
    chk("rst_valid", int'(left_valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    rst_n = 1;
    tick();

    // k=4, continuous operands
    clear_log();
    a_valid_i = 1; b_valid_i = 1;
    send(4, 0, 0, 0); tick(); cmd_valid_i = 0;
    wait_done("t1", 100);
    chk("t1_nbeats", q_cnt.size(), 4);
    for (int i = 0; i < q_cnt.size(); i++) chk("t1_cnt", q_cnt[i], i);
    chk("t1_done_lat", done_c - last_fire, 17);
    tick();

    // k=3, B stalls two cycles on beat 1
    clear_log();
    send(3, 0, 1, 0); tick(); cmd_valid_i = 0;
    tick();
    b_valid_i = 0; tick(); tick();
    b_valid_i = 1;
    wait_done("t2", 100);
    chk("t2_nbeats", q_cnt.size(), 3);
    for (int i = 0; i < q_cnt.size(); i++) chk("t2_cnt", q_cnt[i], i);
    chk("t2_valid_span", last_v - first_v, 4);
    chk("t2_nfire", n_rdy, 3);
`ifdef SARRAY_FEED_PERF_EN
    chk("t2_stall", int'(stall_cnt_o), 2);
`endif
    tick();

    // k=0: no beats, done the cycle after accept
    clear_log();
    acc_c = m_cyc;
    send(0, 1, 3, 1); tick(); cmd_valid_i = 0;
    wait_done("t3", 10);
    chk("t3_done_lat", done_c - acc_c, 1);
    chk("t3_nfire", n_rdy, 0);
    chk("t3_nvalid", q_cnt.size(), 0);
    chk("t3_ready_back", int'(cmd_ready_o), 1);

    // k=2, reset during drain, then k=1
    send(2, 0, 0, 0); tick(); cmd_valid_i = 0;
    repeat (5) tick();
    clear_log();
    rst_n = 0; #1;
    chk("t4_busy", int'(busy_o), 0);
    chk("t4_valid", int'(left_valid_o), 0);
    chk("t4_cnt", int'(left_cnt_o), 0);
    chk("t4_ready", int'(cmd_ready_o), 1);
    tick(); rst_n = 1;
    repeat (25) tick();
    chk("t4_no_done", n_done, 0);
    send(1, 1, 0, 0); tick(); cmd_valid_i = 0;
    wait_done("t4b", 40);
    chk("t4b_nbeats", q_cnt.size(), 1);
    tick();

    // metadata held across beats; cmd toggling during FEED ignored
    clear_log();
    b_valid_i = 0;
    send(2, 1, 2, 1); tick();
    send(7, 0, 1, 0); tick();
    cmd_valid_i = 0; b_valid_i = 1; tick();
    cmd_valid_i = 1; tick();
    cmd_valid_i = 0;
    wait_done("t5", 40);
    chk("t5_nbeats", q_cnt.size(), 2);
    for (int i = 0; i < q_meta.size(); i++) chk("t5_meta", int'(q_meta[i]), 'b1101);
    tick();

    // randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      cmd_valid_i = ($urandom_range(0, 3) == 0);
      cmd_k_i = ($urandom_range(0, 60) == 0) ? CW'(255) : CW'($urandom_range(0, 6));
      cmd_type_i = 1'($urandom); cmd_precision_i = PW'($urandom); cmd_acc_i = 1'($urandom);
      a_valid_i = ($urandom_range(0, 9) < 7);
      b_valid_i = ($urandom_range(0, 9) < 7);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1; cmd_valid_i = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
